uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//   Sits between uart_rx and the memory-load write FSM in the FPGA CPU harness.
//   Parses the host byte stream (START, 4 payload bytes, STOP) into one
//   validated {addr[9:0], data[11:0]} write request with a valid/ready handshake.
//   Also decodes the memory-dump command byte.
//   Flags and counts malformed frames, overruns and inter-byte timeouts.
// PARAMETERS
//   START_BYTE      8'hF5   frame start marker
//   STOP_BYTE       8'hFA   frame stop marker
//   DUMP_BYTE       8'hF6   memory read-out command
//   TIMEOUT_CYCLES  250000  max clk cycles between bytes inside a frame (10 ms @ 25 MHz); 0 disables
// PORTS
//   clk          in   1   system clock (25 MHz)
//   rst          in   1   synchronous, active-high reset
//   rx_data      in   8   byte from uart_rx, valid when rx_valid=1
//   rx_valid     in   1   single-cycle strobe, one per received byte
//   wr_addr      out  10  decoded write address, stable while wr_valid=1
//   wr_data      out  12  decoded write data, stable while wr_valid=1
//   wr_valid     out  1   write request pending; held until wr_ready
//   wr_ready     in   1   consumer accepts request when wr_valid & wr_ready
//   dump_req     out  1   1-cycle pulse: DUMP_BYTE received while IDLE
//   busy         out  1   1 in any state except IDLE
//   frame_err    out  1   1-cycle pulse per malformed or timed-out frame
//   ovr_err      out  1   1-cycle pulse per byte dropped in HOLD
//   err_count    out  8   frame_err + ovr_err events, saturates at 255
//   frame_count  out  8   accepted writes (wr_valid & wr_ready), wraps 255->0
// BEHAVIOUR
//   Reset: all outputs 0. State=IDLE, byte index=0, timeout counter=0. Reset
//     mid-frame or mid-HOLD discards the frame. wr_valid is 0 on the next cycle.
//   Payload format: b0={3'b0,addr[9:5]}, b1={3'b0,addr[4:0]},
//     b2={2'b0,data[11:6]}, b3={2'b0,data[5:0]}.
//     A payload byte with nonzero reserved upper bits is an error.
//   All outputs are registered. An event on rx_valid at cycle N shows on outputs at N+1.
//   IDLE:
//     START -> PAYLOAD, index=0.
//     DUMP -> dump_req pulse.
//     STOP -> frame_err.
//     Any other byte is ignored silently.
//   PAYLOAD:
//     Valid payload byte -> store it, index+1. After b3 -> WAIT_STOP.
//     START -> frame_err, restart PAYLOAD at index 0.
//     STOP, DUMP or bad reserved bits -> frame_err, go to IDLE.
//   WAIT_STOP:
//     STOP -> load wr_addr/wr_data, wr_valid=1, go to HOLD.
//     START -> frame_err, restart PAYLOAD at index 0.
//     Any other byte -> frame_err, go to IDLE.
//   HOLD:
//     wr_valid stays 1; wr_addr/wr_data are frozen.
//     On wr_valid & wr_ready: wr_valid=0 next cycle, frame_count+1, go to IDLE.
//     Any rx_valid in HOLD: byte is dropped and ovr_err pulses. If the same cycle
//     has wr_ready=1, the handshake still completes.
//   Timeout (PAYLOAD/WAIT_STOP only):
//     Counter clears on every rx_valid and on entering the state.
//     Reaching TIMEOUT_CYCLES -> frame_err, go to IDLE.
//     The counter is frozen in IDLE/HOLD.
//   wr_addr/wr_data keep their last accepted value after the handshake; they
//     are never updated by a partial frame.
//   err_count: increments by 1 per cycle with frame_err or ovr_err (a cycle
//     with both counts 1). Holds at 255.
//   Simultaneous events on one cycle:
//     - Timeout expiry and rx_valid together: the byte wins and the counter clears.
//     - START in IDLE followed by rx_valid on the next cycle is legal.
// TESTING
//   1. F5,02,1F,3A,05,FA with wr_ready=1 -> wr_valid 1 cycle after FA;
//      wr_addr=10'h05F, wr_data=12'hE85; frame_count=1.
//   2. Same frame, wr_ready=0 for 20 cycles then 1 -> wr_valid held for 21
//      cycles with stable addr/data; one write only.
//   3. F5,01,02,FA -> frame_err pulse, err_count=1, no wr_valid; then
//      F5,00,00,00,01,FA -> addr=0, data=1 accepted.
//   4. F5,01,FF,... -> frame_err on FF (reserved bits set), state IDLE;
//      F6 in IDLE -> dump_req single pulse. F6 inside a frame -> frame_err, no dump_req.
//   5. F5,03, then silence TIMEOUT_CYCLES -> frame_err exactly TIMEOUT_CYCLES
//      cycles after 03; busy falls to 0 the same cycle.
//   6. Hold wr_ready=0 in HOLD; send F5 -> ovr_err, byte dropped. Then assert
//      rst mid-frame -> all outputs 0 next cycle. Force 300 errors -> err_count=255.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// ============================================================================
// uart_frame_decoder
//
// Purpose:
//   Sits between uart_rx and the memory-load write FSM of the FPGA CPU harness.
//   Parses the host byte stream (START, four payload bytes, STOP) into a single
//   {addr[9:0], data[11:0]} write request. The request is offered with a
//   valid/ready handshake. The block also recognises the memory-dump command
//   byte. It flags and counts malformed frames, overruns and inter-byte
//   timeouts.
//
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   rx_data      in   8   received byte, qualified by rx_valid
//   rx_valid     in   1   single-cycle strobe per received byte
//   wr_addr      out  10  decoded write address (stable while wr_valid)
//   wr_data      out  12  decoded write data (stable while wr_valid)
//   wr_valid     out  1   write request pending until wr_ready
//   wr_ready     in   1   consumer accepts when wr_valid & wr_ready
//   dump_req     out  1   one-cycle pulse: DUMP_BYTE seen while idle
//   busy         out  1   high in every state except idle
//   frame_err    out  1   one-cycle pulse per malformed or timed-out frame
//   ovr_err      out  1   one-cycle pulse per byte dropped while holding
//   err_count    out  8   frame_err/ovr_err cycles, saturates at 255
//   frame_count  out  8   accepted writes, wraps 255 -> 0
// ============================================================================
module uart_frame_decoder #(
    parameter logic [7:0]  START_BYTE     = 8'hF5,
    parameter logic [7:0]  STOP_BYTE      = 8'hFA,
    parameter logic [7:0]  DUMP_BYTE      = 8'hF6,
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [9:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        dump_req,
    output logic        busy,
    output logic        frame_err,
    output logic        ovr_err,
    output logic [7:0]  err_count,
    output logic [7:0]  frame_count
);

    // The timer only has to count up to TIMEOUT_CYCLES-1.
    localparam int          TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_WAIT_STOP,
        ST_HOLD
    } state_t;

    state_t        r_state;
    logic [1:0]    r_index;
    logic [TW-1:0] r_timer;
    logic [4:0]    r_addrHi;
    logic [4:0]    r_addrLo;
    logic [5:0]    r_dataHi;
    logic [5:0]    r_dataLo;
    logic [9:0]    r_wrAddr;
    logic [11:0]   r_wrData;
    logic          r_wrValid;
    logic          r_dumpReq;
    logic          r_busy;
    logic          r_frameErr;
    logic          r_ovrErr;
    logic [7:0]    r_errCount;
    logic [7:0]    r_frameCount;

    logic w_byteOk;
    logic w_inFrame;
    logic w_timeout;
    logic w_frameEvt;
    logic w_ovrEvt;

    // Error-event decode. These signals feed both the registered error pulses
    // and the saturating error counter, so the two can never disagree.
    // Address bytes (index 0/1) reserve three upper bits. Data bytes (index
    // 2/3) reserve two. A byte that arrives in the same cycle as timer expiry
    // takes precedence, so the timeout is masked by rx_valid.
    always_comb begin
        w_byteOk   = 1'b0;
        w_inFrame  = 1'b0;
        w_timeout  = 1'b0;
        w_frameEvt = 1'b0;
        w_ovrEvt   = 1'b0;

        if (r_index[1] == 1'b0) begin
            w_byteOk = (rx_data[7:5] == 3'b000);
        end else begin
            w_byteOk = (rx_data[7:6] == 2'b00);
        end

        w_inFrame = (r_state == ST_PAYLOAD) || (r_state == ST_WAIT_STOP);
        w_timeout = TIMEOUT_EN && w_inFrame && !rx_valid && (r_timer == TMAX);

        case (r_state)
            ST_IDLE: begin
                w_frameEvt = rx_valid && (rx_data == STOP_BYTE);
            end
            ST_PAYLOAD: begin
                w_frameEvt = w_timeout ||
                             (rx_valid && ((rx_data == START_BYTE) ||
                                           (rx_data == STOP_BYTE)  ||
                                           (rx_data == DUMP_BYTE)  ||
                                           !w_byteOk));
            end
            ST_WAIT_STOP: begin
                w_frameEvt = w_timeout || (rx_valid && (rx_data != STOP_BYTE));
            end
            ST_HOLD: begin
                w_ovrEvt = rx_valid;
            end
            default: begin
                w_frameEvt = 1'b0;
            end
        endcase
    end

    // Frame FSM plus all registered outputs. busy is registered alongside
    // every state change so that it is a pure flop output. The inter-byte
    // timer runs only inside a frame. It clears on every byte, which covers
    // every entry into the frame states. It is left untouched while idle or
    // holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= 2'd0;
            r_timer      <= '0;
            r_addrHi     <= 5'd0;
            r_addrLo     <= 5'd0;
            r_dataHi     <= 6'd0;
            r_dataLo     <= 6'd0;
            r_wrAddr     <= 10'd0;
            r_wrData     <= 12'd0;
            r_wrValid    <= 1'b0;
            r_dumpReq    <= 1'b0;
            r_busy       <= 1'b0;
            r_frameErr   <= 1'b0;
            r_ovrErr     <= 1'b0;
            r_errCount   <= 8'd0;
            r_frameCount <= 8'd0;
        end else begin
            r_frameErr <= w_frameEvt;
            r_ovrErr   <= w_ovrEvt;
            r_dumpReq  <= 1'b0;

            if ((w_frameEvt || w_ovrEvt) && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end

            if (rx_valid || w_timeout) begin
                r_timer <= '0;
            end else if (w_inFrame) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == START_BYTE) begin
                            r_state <= ST_PAYLOAD;
                            r_index <= 2'd0;
                            r_busy  <= 1'b1;
                        end else if (rx_data == DUMP_BYTE) begin
                            r_dumpReq <= 1'b1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        if (rx_data == START_BYTE) begin
                            r_index <= 2'd0;
                        end else if ((rx_data == STOP_BYTE) || (rx_data == DUMP_BYTE) || !w_byteOk) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            case (r_index)
                                2'd0:    r_addrHi <= rx_data[4:0];
                                2'd1:    r_addrLo <= rx_data[4:0];
                                2'd2:    r_dataHi <= rx_data[5:0];
                                default: r_dataLo <= rx_data[5:0];
                            endcase
                            if (r_index == 2'd3) begin
                                r_state <= ST_WAIT_STOP;
                            end
                            r_index <= r_index + 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_WAIT_STOP: begin
                    if (rx_valid) begin
                        if (rx_data == STOP_BYTE) begin
                            r_wrAddr  <= {r_addrHi, r_addrLo};
                            r_wrData  <= {r_dataHi, r_dataLo};
                            r_wrValid <= 1'b1;
                            r_state   <= ST_HOLD;
                        end else if (rx_data == START_BYTE) begin
                            r_state <= ST_PAYLOAD;
                            r_index <= 2'd0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (r_wrValid && wr_ready) begin
                        r_wrValid    <= 1'b0;
                        r_frameCount <= r_frameCount + 8'd1;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign wr_valid    = r_wrValid;
    assign dump_req    = r_dumpReq;
    assign busy        = r_busy;
    assign frame_err   = r_frameErr;
    assign ovr_err     = r_ovrErr;
    assign err_count   = r_errCount;
    assign frame_count = r_frameCount;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ============================================================================
// tb_uart_frame_decoder
//
// Directed testbench for uart_frame_decoder. The inter-byte timeout is
// shortened so that silence can be exercised quickly. Inputs change 1 ns
// after each rising edge, and outputs are sampled at that same point.
// ============================================================================
module tb_uart_frame_decoder;

    localparam int TOUT = 40;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        dump_req;
    logic        busy;
    logic        frame_err;
    logic        ovr_err;
    logic [7:0]  err_count;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    uart_frame_decoder #(
        .START_BYTE    (8'hF5),
        .STOP_BYTE     (8'hFA),
        .DUMP_BYTE     (8'hF6),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .dump_req   (dump_req),
        .busy       (busy),
        .frame_err  (frame_err),
        .ovr_err    (ovr_err),
        .err_count  (err_count),
        .frame_count(frame_count)
    );

    // 25 MHz-style free-running clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one clock
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(8'hF5);
        applyStimulus(b0);
        applyStimulus(b1);
        applyStimulus(b2);
        applyStimulus(b3);
        applyStimulus(8'hFA);
    endtask

    // Reset values of every output
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid got %b want 0", wr_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (wr_addr !== 10'h000 || wr_data !== 12'h000) begin errors++; $display("[TB] FAIL reset_addr_data got %h/%h want 000/000", wr_addr, wr_data); end
        checks++; if (err_count !== 8'd0 || frame_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", err_count, frame_count); end
        checks++; if (frame_err !== 1'b0 || ovr_err !== 1'b0 || dump_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b%b%b want 000", frame_err, ovr_err, dump_req); end
    endtask

    // Basic frame with the consumer always ready
    task automatic test_basic_write();
        wr_ready = 1'b1;
        sendFrame(8'h02, 8'h1F, 8'h3A, 8'h05);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_wr_valid got %b want 1", wr_valid); end
        checks++; if (wr_addr !== 10'h05F) begin errors++; $display("[TB] FAIL basic_addr got %h want 05f", wr_addr); end
        checks++; if (wr_data !== 12'hE85) begin errors++; $display("[TB] FAIL basic_data got %h want e85", wr_data); end
        step();
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_release got valid=%b busy=%b want 0/0", wr_valid, busy); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("[TB] FAIL basic_frame_count got %0d want 1", frame_count); end
    endtask

    // Consumer stalls for 20 cycles; the request must be held and stable
    task automatic test_backpressure();
        int  highCycles;
        logic stable;
        highCycles = 0;
        stable     = 1'b1;
        wr_ready   = 1'b0;
        sendFrame(8'h02, 8'h1F, 8'h3A, 8'h05);
        for (int i = 0; i < 20; i++) begin
            if (wr_valid === 1'b1) highCycles++;
            if (wr_addr !== 10'h05F || wr_data !== 12'hE85) stable = 1'b0;
            step();
        end
        wr_ready = 1'b1;
        if (wr_valid === 1'b1) highCycles++;
        step();
        checks++; if (highCycles !== 21) begin errors++; $display("[TB] FAIL bp_hold_cycles got %0d want 21", highCycles); end
        checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable got %b want 1", stable); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got %b want 0", wr_valid); end
        step();
        checks++; if (frame_count !== 8'd2) begin errors++; $display("[TB] FAIL bp_one_write got %0d want 2", frame_count); end
    endtask

    // Short frame is rejected, then a good frame with zero address is taken
    task automatic test_short_frame();
        wr_ready = 1'b1;
        applyStimulus(8'hF5);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'hFA);
        checks++; if (frame_err !== 1'b1 || wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_err got err=%b valid=%b want 1/0", frame_err, wr_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL short_err_count got %0d want 1", err_count); end
        step();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL short_err_pulse got %b want 0", frame_err); end
        sendFrame(8'h00, 8'h00, 8'h00, 8'h01);
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 10'h000 || wr_data !== 12'h001) begin errors++; $display("[TB] FAIL short_recover got %b %h %h want 1 000 001", wr_valid, wr_addr, wr_data); end
        step();
        checks++; if (frame_count !== 8'd3) begin errors++; $display("[TB] FAIL short_frame_count got %0d want 3", frame_count); end
    endtask

    // Reserved bits, dump in idle, dump inside a frame
    task automatic test_reserved_dump();
        applyStimulus(8'hF5);
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        checks++; if (frame_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL resv_err got err=%b busy=%b want 1/0", frame_err, busy); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL resv_err_count got %0d want 2", err_count); end
        applyStimulus(8'hF6);
        checks++; if (dump_req !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL dump_pulse got dump=%b err=%b want 1/0", dump_req, frame_err); end
        step();
        checks++; if (dump_req !== 1'b0) begin errors++; $display("[TB] FAIL dump_single got %b want 0", dump_req); end
        applyStimulus(8'hF5);
        applyStimulus(8'hF6);
        checks++; if (frame_err !== 1'b1 || dump_req !== 1'b0) begin errors++; $display("[TB] FAIL dump_in_frame got err=%b dump=%b want 1/0", frame_err, dump_req); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("[TB] FAIL dump_err_count got %0d want 3", err_count); end
    endtask

    // Silence after a payload byte must time out exactly TOUT cycles later
    task automatic test_timeout();
        int  errAt;
        logic busyBefore;
        logic busyAt;
        errAt      = -1;
        busyBefore = 1'b0;
        busyAt     = 1'b1;
        applyStimulus(8'hF5);
        applyStimulus(8'h03);
        for (int k = 1; k <= TOUT + 5; k++) begin
            step();
            if (k == TOUT - 1) busyBefore = busy;
            if (k == TOUT) busyAt = busy;
            if (frame_err === 1'b1 && errAt < 0) errAt = k;
        end
        checks++; if (errAt !== TOUT) begin errors++; $display("[TB] FAIL timeout_cycle got %0d want %0d", errAt, TOUT); end
        checks++; if (busyBefore !== 1'b1 || busyAt !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got %b->%b want 1->0", busyBefore, busyAt); end
        checks++; if (err_count !== 8'd4) begin errors++; $display("[TB] FAIL timeout_err_count got %0d want 4", err_count); end
    endtask

    // Bytes arriving while a request is held are dropped
    task automatic test_overrun();
        wr_ready = 1'b0;
        sendFrame(8'h1F, 8'h1F, 8'h3F, 8'h3F);
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 10'h3FF || wr_data !== 12'hFFF) begin errors++; $display("[TB] FAIL ovr_setup got %b %h %h want 1 3ff fff", wr_valid, wr_addr, wr_data); end
        applyStimulus(8'hF5);
        checks++; if (ovr_err !== 1'b1 || wr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_drop got ovr=%b valid=%b busy=%b want 1/1/1", ovr_err, wr_valid, busy); end
        checks++; if (err_count !== 8'd5 || wr_addr !== 10'h3FF) begin errors++; $display("[TB] FAIL ovr_count got %0d %h want 5 3ff", err_count, wr_addr); end
        step();
        checks++; if (ovr_err !== 1'b0) begin errors++; $display("[TB] FAIL ovr_pulse got %b want 0", ovr_err); end
        // byte and handshake in the same cycle: both take effect
        wr_ready = 1'b1;
        applyStimulus(8'h00);
        checks++; if (ovr_err !== 1'b1 || wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_with_ready got ovr=%b valid=%b want 1/0", ovr_err, wr_valid); end
        checks++; if (frame_count !== 8'd4 || err_count !== 8'd6) begin errors++; $display("[TB] FAIL ovr_counts got %0d/%0d want 4/6", frame_count, err_count); end
        checks++; if (wr_addr !== 10'h3FF || wr_data !== 12'hFFF) begin errors++; $display("[TB] FAIL ovr_keep got %h %h want 3ff fff", wr_addr, wr_data); end
    endtask

    // Reset while holding a request and while in the middle of a frame
    task automatic test_reset_midframe();
        wr_ready = 1'b0;
        sendFrame(8'h02, 8'h1F, 8'h3A, 8'h05);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 10'h000 || wr_data !== 12'h000) begin errors++; $display("[TB] FAIL rst_hold got %b %b %h %h want 0 0 000 000", wr_valid, busy, wr_addr, wr_data); end
        checks++; if (err_count !== 8'd0 || frame_count !== 8'd0) begin errors++; $display("[TB] FAIL rst_counts got %0d/%0d want 0/0", err_count, frame_count); end
        wr_ready = 1'b1;
        applyStimulus(8'hF5);
        applyStimulus(8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
        // remainder of the old frame must not produce a write
        applyStimulus(8'h02);
        applyStimulus(8'h1F);
        applyStimulus(8'h3A);
        applyStimulus(8'hFA);
        checks++; if (wr_valid !== 1'b0 || frame_err !== 1'b1) begin errors++; $display("[TB] FAIL rst_discard got valid=%b err=%b want 0/1", wr_valid, frame_err); end
        step();
        checks++; if (frame_count !== 8'd0 || err_count !== 8'd1) begin errors++; $display("[TB] FAIL rst_discard_counts got %0d/%0d want 0/1", frame_count, err_count); end
    endtask

    // Many stray STOP bytes in idle drive the error counter into saturation
    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'hFA);
            if (i == 254) begin
                checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_reach got %0d want 255", err_count); end
            end
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold got %0d want 255", err_count); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL sat_pulse got %b want 1", frame_err); end
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        wr_ready = 1'b0;
        #1;
        test_reset();
        test_basic_write();
        test_backpressure();
        test_short_frame();
        test_reserved_dump();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
